// File: rtl/conv2_window_feeder.sv
// Sliding-window feeder for the conv2 layer: four channel histories, KERNEL taps each,
// emitting aligned windows on a valid/ready port with frame tracking and flush.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no window pending, inputs flow freely
// ST_HOLD  | window on win1..win4 is valid, waiting for w_ready
module conv2_window_feeder #(
    parameter int DATA_W  = 8,
    parameter int KERNEL  = 5,
    parameter int SEQ_LEN = 64,
    parameter int STRIDE  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [DATA_W-1:0]   s_ch1,
    input  logic signed [DATA_W-1:0]   s_ch2,
    input  logic signed [DATA_W-1:0]   s_ch3,
    input  logic signed [DATA_W-1:0]   s_ch4,
    output logic [KERNEL*DATA_W-1:0]   win1,
    output logic [KERNEL*DATA_W-1:0]   win2,
    output logic [KERNEL*DATA_W-1:0]   win3,
    output logic [KERNEL*DATA_W-1:0]   win4,
    output logic                       w_valid,
    input  logic                       w_ready,
    output logic                       w_last,
    output logic [15:0]                win_idx,
    output logic                       en
);

    localparam int WIN_W  = KERNEL * DATA_W;
    localparam int CNT_W  = $clog2(SEQ_LEN + 1);
    localparam int FILL_W = $clog2(KERNEL + 1);
    localparam int STR_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SEQ_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(KERNEL - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(KERNEL);
    localparam logic [STR_W-1:0]  STR_LAST = STR_W'(STRIDE - 1);

    typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   sample_q;
    logic [FILL_W-1:0]  fill_q;
    logic [STR_W-1:0]   stride_q;
    logic [WIN_W-1:0]   hist_q [4];
    logic [DATA_W-1:0]  s_ch   [4];

    logic handshake, accept, fill_done, emit, frame_end;

    assign s_ch[0] = s_ch1;
    assign s_ch[1] = s_ch2;
    assign s_ch[2] = s_ch3;
    assign s_ch[3] = s_ch4;

    assign handshake = w_valid & w_ready;
    assign accept    = s_valid & s_ready;
    assign fill_done = (fill_q >= FILL_PRE);
    assign emit      = accept & fill_done & (stride_q == '0);
    assign frame_end = accept & (sample_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (emit) begin
            state_d = ST_HOLD;
        end else if (handshake) begin
            state_d = ST_EMPTY;
        end
    end

    // s_ready looks straight through to w_ready so a window can drain while the next sample lands
    always_comb begin
        w_valid = (state_q == ST_HOLD);
        en      = w_valid & w_ready;
        s_ready = !flush & (!w_valid | w_ready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q <= '0;
            fill_q   <= '0;
            stride_q <= '0;
            win_idx  <= '0;
            w_last   <= 1'b0;
        end else if (flush) begin
            sample_q <= '0;
            fill_q   <= '0;
            stride_q <= '0;
            win_idx  <= '0;
            w_last   <= 1'b0;
        end else begin
            if (handshake) begin
                win_idx <= w_last ? 16'd0 : win_idx + 16'd1;
                w_last  <= 1'b0;
            end
            if (emit) begin
                w_last <= frame_end;
            end
            if (accept) begin
                if (frame_end) begin
                    sample_q <= '0;
                    fill_q   <= '0;
                    stride_q <= '0;
                end else begin
                    sample_q <= sample_q + CNT_W'(1);
                    if (fill_q != FILL_MAX) begin
                        fill_q <= fill_q + FILL_W'(1);
                    end
                    if (fill_done) begin
                        stride_q <= (stride_q == STR_LAST) ? '0 : stride_q + STR_W'(1);
                    end
                end
            end
        end
    end

    // newest sample enters at the top lane, oldest sits in bits [DATA_W-1:0]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                hist_q[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < 4; c++) begin
                hist_q[c] <= {s_ch[c], hist_q[c][WIN_W-1:DATA_W]};
            end
        end
    end

    assign win1 = hist_q[0];
    assign win2 = hist_q[1];
    assign win3 = hist_q[2];
    assign win4 = hist_q[3];

endmodule

// File: tb/tb_conv2_window_feeder.sv
// Bench for conv2_window_feeder: two instances (SEQ_LEN=8/STRIDE=1 and SEQ_LEN=11/STRIDE=3)
// compared every cycle against a frame-position reference model.
module tb_conv2_window_feeder;
    localparam int K  = 5;
    localparam int DW = 8;
    localparam int WW = K * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          fl [2];
    logic          sv [2];
    logic          wr [2];
    logic [DW-1:0] sc [2][4];
    logic          sr_o [2];
    logic          wv_o [2];
    logic          wl_o [2];
    logic          en_o [2];
    logic [15:0]   idx_o [2];
    logic [WW-1:0] win_o [2][4];

    conv2_window_feeder #(.DATA_W(DW), .KERNEL(K), .SEQ_LEN(8), .STRIDE(1)) dut0 (
        .clk(clk), .rst(rst), .flush(fl[0]), .s_valid(sv[0]), .s_ready(sr_o[0]),
        .s_ch1(sc[0][0]), .s_ch2(sc[0][1]), .s_ch3(sc[0][2]), .s_ch4(sc[0][3]),
        .win1(win_o[0][0]), .win2(win_o[0][1]), .win3(win_o[0][2]), .win4(win_o[0][3]),
        .w_valid(wv_o[0]), .w_ready(wr[0]), .w_last(wl_o[0]), .win_idx(idx_o[0]), .en(en_o[0])
    );

    conv2_window_feeder #(.DATA_W(DW), .KERNEL(K), .SEQ_LEN(11), .STRIDE(3)) dut1 (
        .clk(clk), .rst(rst), .flush(fl[1]), .s_valid(sv[1]), .s_ready(sr_o[1]),
        .s_ch1(sc[1][0]), .s_ch2(sc[1][1]), .s_ch3(sc[1][2]), .s_ch4(sc[1][3]),
        .win1(win_o[1][0]), .win2(win_o[1][1]), .win3(win_o[1][2]), .win4(win_o[1][3]),
        .w_valid(wv_o[1]), .w_ready(wr[1]), .w_last(wl_o[1]), .win_idx(idx_o[1]), .en(en_o[1])
    );

    int n_checks = 0;
    int n_err    = 0;
    int seq_len [2] = '{8, 11};
    int stride  [2] = '{1, 3};

    // reference model: frame position plus the samples of the current frame
    bit            mv [2];
    bit            ml [2];
    int            mi [2];
    int            mp [2];
    logic [DW-1:0] frame [2][4][16];
    logic [DW-1:0] mw [2][4][K];
    bit            acc_q [2];
    int            en_cnt [2];
    int            last_cnt [2];
    logic [WW-1:0] cap [$];

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] exp_win(input int d, input int c);
        logic [WW-1:0] r;
        for (int k = 0; k < K; k++) r[k*DW +: DW] = mw[d][c][k];
        return r;
    endfunction

    function automatic logic [WW-1:0] ramp(input int start);
        logic [WW-1:0] r;
        for (int k = 0; k < K; k++) r[k*DW +: DW] = DW'(start + k);
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 0; ml[d] = 0; mi[d] = 0; mp[d] = 0; acc_q[d] = 0;
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < K; k++) mw[d][c][k] = '0;
        end
    endtask

    task automatic idle(input int d);
        sv[d] = 0; wr[d] = 1; fl[d] = 0;
        for (int c = 0; c < 4; c++) sc[d][c] = '0;
    endtask

    // called at a falling edge with inputs already driven
    task automatic tick();
        bit exp_sr, hs, emit;
        int p;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_sr = !fl[d] && (!mv[d] || wr[d]);
            chk("s_ready", d, 64'(sr_o[d]), 64'(exp_sr));
            chk("w_valid", d, 64'(wv_o[d]), 64'(mv[d]));
            chk("en", d, 64'(en_o[d]), 64'(mv[d] && wr[d]));
            chk("win_idx", d, 64'(idx_o[d]), 64'(mi[d]));
            if (mv[d]) begin
                chk("w_last", d, 64'(wl_o[d]), 64'(ml[d]));
                for (int c = 0; c < 4; c++) chk("win", d, 64'(win_o[d][c]), 64'(exp_win(d, c)));
            end
            if (en_o[d]) begin
                en_cnt[d]++;
                if (wl_o[d]) last_cnt[d]++;
                if (d == 0) cap.push_back(win_o[0][0]);
            end

            acc_q[d] = sv[d] && exp_sr;
            hs = mv[d] && wr[d];
            if (fl[d]) begin
                mv[d] = 0; ml[d] = 0; mi[d] = 0; mp[d] = 0;
            end else begin
                emit = 0;
                if (hs) begin
                    mi[d] = ml[d] ? 0 : mi[d] + 1;
                    mv[d] = 0;
                    ml[d] = 0;
                end
                if (acc_q[d]) begin
                    p = mp[d];
                    for (int c = 0; c < 4; c++) frame[d][c][p] = sc[d][c];
                    if (p >= K - 1 && (p - (K - 1)) % stride[d] == 0) begin
                        for (int c = 0; c < 4; c++)
                            for (int k = 0; k < K; k++) mw[d][c][k] = frame[d][c][p - K + 1 + k];
                        ml[d] = (p == seq_len[d] - 1);
                        mi[d] = (p - (K - 1)) / stride[d];
                        mv[d] = 1;
                    end
                    mp[d] = (p == seq_len[d] - 1) ? 0 : p + 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // source that holds each sample until accepted; optional stall on one window index
    task automatic stream(input int d, input int n, input int start, input bit ext,
                          input int st_idx, input int st_len, input bit drain);
        int i = 0;
        int stalls = 0;
        int cyc = 0;
        while (i < n && cyc < 300) begin
            sv[d] = 1;
            sc[d][0] = DW'(start + i);
            sc[d][1] = DW'(-(start + i));
            sc[d][2] = ext ? ((i % 2) ? 8'h7F : 8'h80) : DW'($urandom);
            sc[d][3] = ext ? ((i % 2) ? 8'h80 : 8'h7F) : DW'($urandom);
            wr[d] = 1;
            if (mv[d] && mi[d] == st_idx && stalls < st_len) begin
                wr[d] = 0;
                stalls++;
            end
            tick();
            if (acc_q[d]) i++;
            cyc++;
        end
        chk("stream_accepts", d, 64'(i), 64'(n));
        if (drain) begin
            sv[d] = 0; wr[d] = 1;
            tick();
            tick();
        end
    endtask

    initial begin
        int b, l;
        model_reset();
        idle(0);
        idle(1);
        #1 rst = 0;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_w_valid", d, 64'(wv_o[d]), 64'd0);
            chk("rst_w_last", d, 64'(wl_o[d]), 64'd0);
            chk("rst_win_idx", d, 64'(idx_o[d]), 64'd0);
            for (int c = 0; c < 4; c++) chk("rst_win", d, 64'(win_o[d][c]), 64'd0);
        end
        rst = 1;
        tick();

        // ramp 1..8 with consumer always ready
        b = en_cnt[0]; l = last_cnt[0];
        stream(0, 8, 1, 0, -1, 0, 1);
        chk("ramp_windows", 0, 64'(en_cnt[0] - b), 64'd4);
        chk("ramp_lasts", 0, 64'(last_cnt[0] - l), 64'd1);

        // three stall cycles while window index 1 is presented
        b = en_cnt[0];
        stream(0, 8, 1, 0, 1, 3, 1);
        chk("bp_windows", 0, 64'(en_cnt[0] - b), 64'd4);

        // strided instance
        b = en_cnt[1]; l = last_cnt[1];
        stream(1, 11, 0, 0, -1, 0, 1);
        chk("stride_windows", 1, 64'(en_cnt[1] - b), 64'd3);
        chk("stride_lasts", 1, 64'(last_cnt[1] - l), 64'd1);

        // two frames back to back
        cap.delete();
        b = en_cnt[0]; l = last_cnt[0];
        stream(0, 16, 1, 0, -1, 0, 1);
        chk("b2b_windows", 0, 64'(en_cnt[0] - b), 64'd8);
        chk("b2b_lasts", 0, 64'(last_cnt[0] - l), 64'd2);
        chk("b2b_captured", 0, 64'(cap.size()), 64'd8);
        if (cap.size() > 4) chk("b2b_frame2_first", 0, 64'(cap[4]), 64'(ramp(9)));

        // flush with a pending window and a sample on the input
        stream(0, 6, 1, 0, -1, 0, 0);
        sv[0] = 1; sc[0][0] = 8'd99; wr[0] = 0; fl[0] = 1;
        tick();
        fl[0] = 0;
        chk("flush_w_valid", 0, 64'(wv_o[0]), 64'd0);
        cap.delete();
        stream(0, 5, 20, 0, -1, 0, 1);
        chk("flush_captured", 0, 64'(cap.size()), 64'd1);
        if (cap.size() > 0) chk("flush_window", 0, 64'(cap[0]), 64'(ramp(20)));

        // asynchronous reset while a window is pending
        stream(0, 5, 1, 1, -1, 0, 0);
        sv[0] = 0; wr[0] = 0;
        #2 rst = 0;
        #1;
        chk("arst_w_valid", 0, 64'(wv_o[0]), 64'd0);
        chk("arst_en", 0, 64'(en_o[0]), 64'd0);
        chk("arst_w_last", 0, 64'(wl_o[0]), 64'd0);
        chk("arst_win_idx", 0, 64'(idx_o[0]), 64'd0);
        for (int c = 0; c < 4; c++) chk("arst_win", 0, 64'(win_o[0][c]), 64'd0);
        model_reset();
        idle(0);
        @(negedge clk);
        rst = 1;
        b = en_cnt[0];
        stream(0, 8, 1, 1, -1, 0, 1);
        chk("post_rst_windows", 0, 64'(en_cnt[0] - b), 64'd4);

        // random traffic on both instances
        for (int t = 0; t < 600; t++) begin
            for (int d = 0; d < 2; d++) begin
                sv[d] = ($urandom_range(3) != 0);
                wr[d] = ($urandom_range(2) != 0);
                fl[d] = ($urandom_range(49) == 0);
                for (int c = 0; c < 4; c++)
                    sc[d][c] = ($urandom_range(7) == 0) ? 8'h80 : DW'($urandom);
            end
            tick();
        end
        idle(0);
        idle(1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv2_window_feeder.md
Name: conv2_window_feeder

Overview:
Streaming window generator that drives the second convolution layer. It accepts one 8-bit signed sample per channel per cycle from the layer-1 output stream (4 channels) and keeps a KERNEL-deep shift history per channel. It emits aligned 5-tap sliding windows win1..win4 together with the `en` strobe that the conv layer consumes. Output uses a valid/ready handshake with backpressure; frame boundaries are tracked by an internal counter.

Parameters:
DATA_W, 8, sample width (signed)
KERNEL, 5, taps per window; must match the conv layer filter length
SEQ_LEN, 64, samples per channel per frame; constraint: SEQ_LEN >= KERNEL
STRIDE, 1, samples between consecutive window starts; constraint: (SEQ_LEN-KERNEL) % STRIDE == 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous frame abort, active-high
s_valid  in  1  input sample set valid
s_ready  out  1  feeder can accept a sample set
s_ch1..s_ch4  in  DATA_W each  signed samples for channels 1..4, same time index
win1..win4  out  KERNEL x DATA_W packed  window per channel; index 0 = oldest sample, index KERNEL-1 = newest
w_valid  out  1  windows valid
w_ready  in  1  consumer accepts windows
w_last  out  1  final window of the frame; qualified by w_valid
win_idx  out  16  window index within the frame, starting at 0
en  out  1  w_valid & w_ready; the conv layer enable

Behaviour:
- Reset (rst=0, asynchronous):
  - w_valid=0, w_last=0, win_idx=0.
  - All window registers, the fill counter, the sample counter and the stride counter are 0.
  - s_ready=1 once reset is released.
- Accept: a sample set is accepted when s_valid & s_ready. On accept:
  - each channel history shifts so that index k takes index k+1, and index KERNEL-1 takes s_chN;
  - sample_cnt increments.
- s_ready = !w_valid | w_ready. This is combinational on w_ready and is intentional. A window output is accepted and a new sample set is taken in the same cycle.
- Window emission:
  - A window is produced when the accepted sample brings fill to >= KERNEL and stride_cnt==0.
  - w_valid rises on the next clock edge. Latency is 1 cycle from the completing accept.
  - stride_cnt counts 0..STRIDE-1, restarts at 0 on each emission, and advances only after fill >= KERNEL.
- Hold: while w_valid & !w_ready:
  - win1..win4, w_last and win_idx stay stable;
  - no input is accepted.
- Output handshake (w_valid & w_ready):
  - win_idx increments, or returns to 0 after w_last;
  - w_valid drops unless a new window is loaded in the same edge.
- Frame end:
  - The accept with sample_cnt == SEQ_LEN-1 always produces a window, guaranteed by the stride constraint; that window has w_last=1.
  - On that accept, sample_cnt, fill and stride_cnt return to 0. The next frame starts filling on the next accepted sample, with no bubble.
  - Windows never span two frames.
- Windows per frame = (SEQ_LEN-KERNEL)/STRIDE + 1.
- flush=1 (synchronous):
  - on the next edge, w_valid=0, w_last=0, win_idx=0, and all counters are 0;
  - any pending window is discarded;
  - an input presented in the same cycle is not accepted (s_ready forced 0 while flush=1);
  - flush has priority over both handshakes.
- Reset mid-frame: all state is cleared immediately; the partial frame is lost.
- Data path: pure register moves, no arithmetic. Values are passed bit-exact, including -128 (0x80).
- en is combinational and is never high while w_valid=0.

Test Plan:
- SEQ_LEN=8, STRIDE=1, w_ready=1; ch1 = 1..8, ch2 = -1..-8 back-to-back:
  - exactly 4 windows, one per cycle starting 1 cycle after the 5th accept;
  - win1 = {1,2,3,4,5}, {2..6}, {3..7}, {4..8};
  - win2 = the negated windows;
  - w_last=1 only on win_idx=3.
- Backpressure: same stimulus, w_ready=0 for 3 cycles while window {2..6} is valid:
  - s_ready=0, window stable;
  - no sample lost; the remaining windows are unchanged after release.
- SEQ_LEN=11, STRIDE=3; samples 0..10:
  - 3 windows, starting with oldest sample 0, 3, 6;
  - w_last on {6..10};
  - samples beyond the last window's start are consumed but produce no extra window.
- Back-to-back frames (SEQ_LEN=8):
  - 16 continuous samples yield 8 windows, w_last on win_idx 3 of each frame;
  - the first window of frame 2 is {9..13}, with no bubble in s_ready.
- flush asserted after the 6th accept:
  - w_valid=0 next edge;
  - the following 5 samples 20..24 produce window {20..24} with win_idx=0.
- Async reset pulse mid-window:
  - all outputs 0 within the reset cycle, without waiting for a clock;
  - after release, behaviour is identical to the first scenario;
  - 0x80 and 0x7F samples pass through unchanged.
